vx_dma_engine: RTL and testbench
================================

VX_DMA_ENGINE -- requirements
Module: VX_dma_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width of source, destination and memory ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width; address stride is DATA_WIDTH/8 bytes.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, meaning width of the transfer length in words.
REQ-004 SHALL have parameter NUM_WARPS, default `NUM_WARPS; NW_WIDTH = `CLOG2(NUM_WARPS) is derived from it.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset (asserted at 0).
REQ-007 SHALL have ports dma_req_valid in 1, dma_req_ready out 1, dma_req_wid in NW_WIDTH, dma_req_src in ADDR_WIDTH, dma_req_dst in ADDR_WIDTH, dma_req_len in LEN_WIDTH: a copy request from the SFU DMA PE.
REQ-008 SHALL have ports dma_done_valid out 1 and dma_done_wid out NW_WIDTH: completion pulse that releases the stalled warp.
REQ-009 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_req_rw out 1 (1=write), mem_req_addr out ADDR_WIDTH, mem_req_data out DATA_WIDTH.
REQ-010 SHALL have ports mem_rsp_valid in 1, mem_rsp_ready out 1, mem_rsp_data in DATA_WIDTH (read data only; writes get no response).
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
REQ-013 SHALL drive dma_req_ready=1 only in IDLE; a request is accepted on dma_req_valid&&dma_req_ready, latching wid, src, dst, len.
REQ-014 SHALL go IDLE->RD_REQ on accept with len!=0, and IDLE->DONE on accept with len==0.
REQ-015 SHALL in RD_REQ drive mem_req_valid=1, rw=0, addr=current src; on mem_req_ready go to RD_WAIT.
REQ-016 SHALL in RD_WAIT drive mem_rsp_ready=1; on mem_rsp_valid latch mem_rsp_data and go to WR_REQ; mem_rsp_ready SHALL be 0 in all other states.
REQ-017 SHALL in WR_REQ drive mem_req_valid=1, rw=1, addr=current dst, data=latched word; on mem_req_ready, src+=DATA_WIDTH/8, dst+=DATA_WIDTH/8, remaining-=1, then DONE if remaining was 1, else RD_REQ.
REQ-018 SHALL hold mem_req_addr/rw/data stable while mem_req_valid=1 and mem_req_ready=0.
REQ-019 SHALL in DONE assert dma_done_valid=1 with dma_done_wid=latched wid for exactly one cycle, then return to IDLE (no backpressure on done).
REQ-020 SHALL wrap address increments modulo 2^ADDR_WIDTH; low log2(DATA_WIDTH/8) address bits pass through unmodified (alignment is the requester's responsibility).
REQ-021 SHALL, with zero-wait memory (ready=1, response one cycle after read handshake), assert dma_done_valid 3*len+1 cycles after the accept edge; len==0 gives 1 cycle.
REQ-022 SHALL ignore dma_req_valid while busy (no queueing; one transfer in flight).
REQ-023 SHALL treat len as unsigned; len=2^LEN_WIDTH-1 SHALL complete without counter overflow.

Reset
REQ-024 SHALL on reset asserted (0), asynchronously force state=IDLE, clear src/dst/remaining/wid/data registers, and drive dma_req_ready=1 only after reset deasserts.
REQ-025 SHALL on reset drive mem_req_valid=0, mem_rsp_ready=0, dma_done_valid=0, dma_done_wid=0, busy=0.
REQ-026 SHALL abandon any in-flight transfer on reset mid-operation without issuing a done pulse; a memory response arriving after reset SHALL be ignored (mem_rsp_ready=0).

Structure
REQ-027 SHALL define dma_req_t (wid, src, dst, len) and DMA_LEN_BITS in VX_gpu_pkg, shared with the SFU DMA PE and VX_dma_bus_if.
REQ-028 SHALL be a single flat module; no sub-module is required (FSM plus datapath registers).

Verification
REQ-029 Single word: src=0x1000, dst=0x2000, len=1, wid=3, zero-wait memory -> one read @0x1000, one write @0x2000 with read data, done_valid with wid=3 at cycle 4.
REQ-030 Burst: len=4, src=0x100, dst=0x200 -> reads 0x100,0x104,0x108,0x10C and writes 0x200..0x20C in order, done at cycle 13.
REQ-031 Zero length: len=0, wid=5 -> no mem_req_valid, done_valid with wid=5 one cycle after accept.
REQ-032 Backpressure: mem_req_ready=0 for 5 cycles in RD_REQ and WR_REQ, response delayed 7 cycles -> addr/data stable, no duplicate requests, correct data written.
REQ-033 Wrap: src=0xFFFFFFFC, len=2 -> second read @0x00000000.
REQ-034 Reset mid-transfer: assert reset in RD_WAIT with len=3 -> outputs at reset values immediately, no done pulse, next request completes normally.

Source files
------------

// File: rtl/vx_gpu_pkg.sv
// Shared DMA types and sizing constants used by the DMA engine, the SFU DMA PE
// and the DMA bus interface.
package vx_gpu_pkg;

  localparam int DMA_ADDR_BITS = 32;
  localparam int DMA_LEN_BITS  = 16;
  localparam int DMA_NUM_WARPS = 8;

  // A single-warp configuration still needs a one-bit warp id field.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DMA_NW_BITS = clog2_min1(DMA_NUM_WARPS);

  typedef struct packed {
    logic [DMA_NW_BITS-1:0]   wid;
    logic [DMA_ADDR_BITS-1:0] src;
    logic [DMA_ADDR_BITS-1:0] dst;
    logic [DMA_LEN_BITS-1:0]  len;
  } dma_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_DONE
  } dma_state_e;

endpackage

// File: rtl/vx_dma_engine.sv
// Word-by-word memory copy engine: read one word, write it back, repeat len times,
// then pulse done with the requesting warp id. One transfer in flight at a time.
module vx_dma_engine
  import vx_gpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = DMA_LEN_BITS,
  parameter int NUM_WARPS  = DMA_NUM_WARPS,
  localparam int NW_WIDTH  = clog2_min1(NUM_WARPS)
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  dma_req_valid,
  output logic                  dma_req_ready,
  input  logic [NW_WIDTH-1:0]   dma_req_wid,
  input  logic [ADDR_WIDTH-1:0] dma_req_src,
  input  logic [ADDR_WIDTH-1:0] dma_req_dst,
  input  logic [LEN_WIDTH-1:0]  dma_req_len,

  output logic                  dma_done_valid,
  output logic [NW_WIDTH-1:0]   dma_done_wid,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rw,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_data,

  input  logic                  mem_rsp_valid,
  output logic                  mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,

  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);

  dma_state_e            state_q, state_d;
  logic [NW_WIDTH-1:0]   wid_q,   wid_d;
  logic [ADDR_WIDTH-1:0] src_q,   src_d;
  logic [ADDR_WIDTH-1:0] dst_q,   dst_d;
  logic [LEN_WIDTH-1:0]  rem_q,   rem_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;

  // NOTE: all state is cleared on reset, including the datapath registers, so an
  // abandoned transfer leaves nothing behind that could leak into the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wid_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_d;
      wid_q   <= wid_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    // NOTE: every signal written below gets a default first, so no path infers a latch.
    state_d        = state_q;
    wid_d          = wid_q;
    src_d          = src_q;
    dst_d          = dst_q;
    rem_d          = rem_q;
    data_d         = data_q;
    dma_req_ready  = 1'b0;
    dma_done_valid = 1'b0;
    dma_done_wid   = '0;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_addr   = src_q;
    mem_req_data   = data_q;
    mem_rsp_ready  = 1'b0;
    busy           = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        // Gated by reset so the requester never sees ready while reset is held.
        dma_req_ready = reset;
        if (dma_req_valid && reset) begin
          wid_d   = dma_req_wid;
          src_d   = dma_req_src;
          dst_d   = dma_req_dst;
          rem_d   = dma_req_len;
          state_d = (dma_req_len == '0) ? ST_DONE : ST_RD_REQ;
        end
      end

      ST_RD_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        mem_rsp_ready = 1'b1;
        if (mem_rsp_valid) begin
          data_d  = mem_rsp_data;
          state_d = ST_WR_REQ;
        end
      end

      ST_WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = dst_q;
        if (mem_req_ready) begin
          // Address adds wrap naturally at ADDR_WIDTH; sub-word bits are untouched.
          src_d   = src_q + STRIDE;
          dst_d   = dst_q + STRIDE;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == LEN_WIDTH'(1)) ? ST_DONE : ST_RD_REQ;
        end
      end

      ST_DONE: begin
        dma_done_valid = 1'b1;
        dma_done_wid   = wid_q;
        state_d        = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vx_dma_engine.sv
// Directed bench for vx_dma_engine: a behavioural memory with configurable stalls and
// read latency, and scoreboards for memory operations and done pulses.
module tb_vx_dma_engine;
  import vx_gpu_pkg::*;

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_op_t;

  typedef struct {
    logic [DMA_NW_BITS-1:0] wid;
    int                     cyc;
  } done_exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   dma_req_valid;
  logic                   dma_req_ready;
  logic [DMA_NW_BITS-1:0] dma_req_wid;
  logic [31:0]            dma_req_src;
  logic [31:0]            dma_req_dst;
  logic [15:0]            dma_req_len;
  logic                   dma_done_valid;
  logic [DMA_NW_BITS-1:0] dma_done_wid;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic                   mem_req_rw;
  logic [31:0]            mem_req_addr;
  logic [31:0]            mem_req_data;
  logic                   mem_rsp_valid;
  logic                   mem_rsp_ready;
  logic [31:0]            mem_rsp_data;
  logic                   busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  mem_op_t   exp_q[$];
  done_exp_t done_q[$];

  // Memory model controls (written only by the main sequence).
  int stall_cfg = 0;
  int rd_lat    = 1;
  bit rsp_drop  = 1'b0;

  vx_dma_engine dut (
    .clk            (clk),
    .reset          (rst_n),
    .dma_req_valid  (dma_req_valid),
    .dma_req_ready  (dma_req_ready),
    .dma_req_wid    (dma_req_wid),
    .dma_req_src    (dma_req_src),
    .dma_req_dst    (dma_req_dst),
    .dma_req_len    (dma_req_len),
    .dma_done_valid (dma_done_valid),
    .dma_done_wid   (dma_done_wid),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_ready  (mem_rsp_ready),
    .mem_rsp_data   (mem_rsp_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hA5C3_9E17;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: decides ready for the coming edge, scores handshakes, returns reads.
  int          stall_left = 0;
  int          rsp_wait   = 0;
  bit          rsp_taken  = 1'b0;
  bit          holding    = 1'b0;
  logic [31:0] rsp_word   = '0;
  logic [31:0] hold_addr, hold_data;
  logic        hold_rw;

  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
  end

  always @(negedge clk) begin
    mem_op_t op;
    if (rsp_drop) begin
      mem_rsp_valid = 1'b0;
      rsp_wait      = 0;
    end
    if (rsp_taken) mem_rsp_valid = 1'b0;
    if (rsp_wait > 0) begin
      rsp_wait--;
      if (rsp_wait == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rsp_word;
      end
    end
    rsp_taken = mem_rsp_valid && mem_rsp_ready;

    if (!mem_req_valid) begin
      mem_req_ready = 1'b0;
      stall_left    = stall_cfg;
      holding       = 1'b0;
    end else begin
      if (holding) begin
        check("hold_addr", mem_req_addr, hold_addr);
        check("hold_rw",   mem_req_rw,   hold_rw);
        check("hold_data", mem_req_data, hold_data);
      end
      if (stall_left > 0) begin
        mem_req_ready = 1'b0;
        if (!holding) begin
          hold_addr = mem_req_addr;
          hold_rw   = mem_req_rw;
          hold_data = mem_req_data;
          holding   = 1'b1;
        end
        stall_left--;
      end else begin
        mem_req_ready = 1'b1;
        holding       = 1'b0;
        stall_left    = stall_cfg;
        if (exp_q.size() == 0) begin
          check("unexpected_mem_req", 1'b1, 1'b0);
        end else begin
          op = exp_q.pop_front();
          check("mem_rw",   mem_req_rw,   op.rw);
          check("mem_addr", mem_req_addr, op.addr);
          if (op.rw) check("mem_wdata", mem_req_data, op.data);
        end
        if (!mem_req_rw) begin
          rsp_wait = rd_lat;
          rsp_word = mem_word(mem_req_addr);
        end
      end
    end
  end

  // Done monitor: every pulse must match a queued expectation, once.
  always @(negedge clk) begin
    done_exp_t de;
    if (dma_done_valid) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        de = done_q.pop_front();
        check("done_wid", dma_done_wid, de.wid);
        // Pulse is seen in the cycle closed by edge accept+3*len+1.
        if (de.cyc >= 0) check("done_latency", cyc, de.cyc);
      end
    end
  end

  task automatic issue(input dma_req_t r, input bit chk_lat, input bit full);
    done_exp_t de;
    @(negedge clk);
    check("req_ready_idle", dma_req_ready, 1'b1);
    if (full) begin
      for (int k = 0; k < int'(r.len); k++) begin
        exp_q.push_back('{1'b0, r.src + 32'(4 * k), 32'h0});
        exp_q.push_back('{1'b1, r.dst + 32'(4 * k), mem_word(r.src + 32'(4 * k))});
      end
    end else if (r.len != 0) begin
      exp_q.push_back('{1'b0, r.src, 32'h0});
    end
    dma_req_valid = 1'b1;
    dma_req_wid   = r.wid;
    dma_req_src   = r.src;
    dma_req_dst   = r.dst;
    dma_req_len   = r.len;
    @(posedge clk);
    #1;
    if (full) begin
      de.wid = r.wid;
      de.cyc = chk_lat ? cyc + 3 * int'(r.len) : -1;
      done_q.push_back(de);
    end
    @(negedge clk);
    dma_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit idle = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0 && done_q.size() == 0) begin
        idle = 1'b1;
        break;
      end
    end
    check(tag, idle, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n         = 1'b0;
    dma_req_valid = 1'b0;
    dma_req_wid   = '0;
    dma_req_src   = '0;
    dma_req_dst   = '0;
    dma_req_len   = '0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready",  dma_req_ready,  1'b0);
    check("rst_mem_valid",  mem_req_valid,  1'b0);
    check("rst_rsp_ready",  mem_rsp_ready,  1'b0);
    check("rst_done_valid", dma_done_valid, 1'b0);
    check("rst_done_wid",   dma_done_wid,   '0);
    check("rst_busy",       busy,           1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_req_ready", dma_req_ready, 1'b1);

    // Single word, zero-wait memory.
    issue('{3'd3, 32'h1000, 32'h2000, 16'd1}, 1'b1, 1'b1);
    wait_idle("idle_single", 50);

    // Four-word burst.
    issue('{3'd0, 32'h100, 32'h200, 16'd4}, 1'b1, 1'b1);
    wait_idle("idle_burst", 100);

    // Zero length: no memory traffic, done one cycle after accept.
    issue('{3'd5, 32'h40, 32'h80, 16'd0}, 1'b1, 1'b1);
    wait_idle("idle_zero", 20);

    // Backpressure on both request types and a slow read response.
    stall_cfg = 5;
    rd_lat    = 7;
    issue('{3'd6, 32'h3000, 32'h4000, 16'd2}, 1'b0, 1'b1);
    wait_idle("idle_backpressure", 200);
    stall_cfg = 0;
    rd_lat    = 1;

    // Source address wraps past the top of the address space.
    issue('{3'd1, 32'hFFFF_FFFC, 32'h500, 16'd2}, 1'b1, 1'b1);
    wait_idle("idle_wrap", 50);

    // Requests presented while busy are neither accepted nor queued.
    issue('{3'd4, 32'h600, 32'h700, 16'd2}, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      dma_req_valid = 1'b1;
      dma_req_wid   = 3'd7;
      dma_req_src   = 32'hA00;
      dma_req_dst   = 32'hB00;
      dma_req_len   = 16'd1;
      #1;
      check("busy_req_ready", dma_req_ready, 1'b0);
      check("busy_flag",      busy,          1'b1);
      @(negedge clk);
    end
    dma_req_valid = 1'b0;
    wait_idle("idle_ignore", 50);

    // Reset while waiting for read data; the late response must be ignored.
    rd_lat = 5;
    issue('{3'd2, 32'h800, 32'h900, 16'd3}, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (mem_rsp_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("reached_rd_wait", seen, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_valid",  mem_req_valid,  1'b0);
    check("midrst_rsp_ready",  mem_rsp_ready,  1'b0);
    check("midrst_busy",       busy,           1'b0);
    check("midrst_req_ready",  dma_req_ready,  1'b0);
    check("midrst_done_valid", dma_done_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (mem_rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("late_rsp_arrived",  seen,          1'b1);
    check("late_rsp_ignored",  mem_rsp_ready, 1'b0);
    check("late_rsp_not_busy", busy,          1'b0);
    rsp_drop = 1'b1;
    @(negedge clk);
    #1;
    rsp_drop = 1'b0;
    rd_lat   = 1;
    check("post_midrst_queue_empty", exp_q.size(), 0);

    // Normal transfer after the abandoned one.
    issue('{3'd1, 32'h1000, 32'h2000, 16'd1}, 1'b1, 1'b1);
    wait_idle("idle_after_reset", 50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
